// File: rtl/fpu_mul_unpack_pkg.sv
// Shared constants and the decoded-operand record for the multiply-pipe operand unpacker.
package fpu_mul_unpack_pkg;

    localparam int DEXP_BIAS = 1023;
    localparam int SEXP_BIAS = 127;
    localparam int EXP_OUT_W = 13;

    localparam logic [10:0] DEXP_MAX = 11'h7ff;
    localparam logic [7:0]  SEXP_MAX = 8'hff;

    // Bit positions inside the flag vector of a decoded operand
    localparam int CLS_ZERO   = 0;
    localparam int CLS_DENORM = 1;
    localparam int CLS_INF    = 2;
    localparam int CLS_NAN    = 3;
    localparam int CLS_SNAN   = 4;
    localparam int CLS_W      = 5;

    typedef struct packed {
        logic                 sign;
        logic [EXP_OUT_W-1:0] exp;
        logic [5:0]           lz;
        logic [CLS_W-1:0]     cls;
    } unpack_t;

endpackage

// File: rtl/fpu_lzc52.sv
// Combinational 52-bit leading-zero counter; an all-zero input reports 52.
module fpu_lzc52 (
    input  logic [51:0] vec_i,
    output logic [5:0]  cnt_o
);

    // Scanning upward lets the highest set bit be the last (winning) assignment.
    always_comb begin
        // NOTE: a default before the loop keeps every path assigned, so no latch is inferred.
        cnt_o = 6'd52;
        for (int i = 0; i < 52; i++) begin
            if (vec_i[i]) cnt_o = 6'(51 - i);
        end
    end

endmodule

// File: rtl/fpu_mul_exp_unpack.sv
// Two-stage step-gated decoder: raw single/double operand to sign, class, unbiased exponent, denormal lz.
module fpu_mul_exp_unpack
    import fpu_mul_unpack_pkg::*;
(
    input  logic                 rclk,
    input  logic                 reset,
    input  logic                 step,
    input  logic                 in_vld,
    input  logic                 in_dbl,
    input  logic [63:0]          in_op,
    output logic                 in_rdy,
    output logic                 out_vld,
    output logic                 out_sign,
    output logic [EXP_OUT_W-1:0] out_exp,
    output logic [5:0]           out_lz,
    output logic                 out_zero,
    output logic                 out_denorm,
    output logic                 out_inf,
    output logic                 out_nan,
    output logic                 out_snan
);

    logic        u1_vld_q;
    logic        u1_dbl_q;
    logic [63:0] u1_op_q;

    logic        out_vld_q;
    unpack_t     out_q;
    unpack_t     out_d;

    assign in_rdy = step;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge rclk) begin
        if (reset) begin
            u1_vld_q <= 1'b0;
            u1_dbl_q <= 1'b0;
            u1_op_q  <= '0;
        end else if (step) begin
            u1_vld_q <= in_vld;
            if (in_vld) begin
                u1_dbl_q <= in_dbl;
                u1_op_q  <= in_op;
            end
        end
    end

    // Single fractions are left-justified and padded with ones so the count stops at 22.
    logic [51:0] lzc_vec;
    logic [5:0]  lzc_cnt;

    assign lzc_vec = u1_dbl_q ? u1_op_q[51:0] : {u1_op_q[54:32], 29'h1fff_ffff};

    fpu_lzc52 u_lzc (
        .vec_i (lzc_vec),
        .cnt_o (lzc_cnt)
    );

    logic                 e_zero;
    logic                 e_max;
    logic                 f_nz;
    logic                 f_msb;
    logic [EXP_OUT_W-1:0] e_ext;
    logic [EXP_OUT_W-1:0] bias;

    always_comb begin
        if (u1_dbl_q) begin
            e_zero = (u1_op_q[62:52] == '0);
            e_max  = (u1_op_q[62:52] == DEXP_MAX);
            f_nz   = |u1_op_q[51:0];
            f_msb  = u1_op_q[51];
            e_ext  = {2'b00, u1_op_q[62:52]};
            bias   = EXP_OUT_W'(DEXP_BIAS);
        end else begin
            e_zero = (u1_op_q[62:55] == '0);
            e_max  = (u1_op_q[62:55] == SEXP_MAX);
            f_nz   = |u1_op_q[54:32];
            f_msb  = u1_op_q[54];
            e_ext  = {5'b00000, u1_op_q[62:55]};
            bias   = EXP_OUT_W'(SEXP_BIAS);
        end
    end

    always_comb begin
        out_d      = '0;
        out_d.sign = u1_op_q[63];
        if (e_zero && !f_nz) begin
            out_d.cls[CLS_ZERO] = 1'b1;
        end else if (e_zero) begin
            out_d.cls[CLS_DENORM] = 1'b1;
            out_d.lz              = lzc_cnt;
            out_d.exp             = EXP_OUT_W'(0) - bias - {7'b0, lzc_cnt};
        end else begin
            out_d.exp = e_ext - bias;
            if (e_max && !f_nz) begin
                out_d.cls[CLS_INF] = 1'b1;
            end else if (e_max) begin
                out_d.cls[CLS_NAN]  = 1'b1;
                out_d.cls[CLS_SNAN] = ~f_msb;
            end
        end
    end

    // NOTE: the output data registers are reset too, so a reset leaves every output at zero.
    always_ff @(posedge rclk) begin
        if (reset) begin
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else if (step) begin
            out_vld_q <= u1_vld_q;
            if (u1_vld_q) out_q <= out_d;
        end
    end

    assign out_vld    = out_vld_q;
    assign out_sign   = out_q.sign;
    assign out_exp    = out_q.exp;
    assign out_lz     = out_q.lz;
    assign out_zero   = out_q.cls[CLS_ZERO];
    assign out_denorm = out_q.cls[CLS_DENORM];
    assign out_inf    = out_q.cls[CLS_INF];
    assign out_nan    = out_q.cls[CLS_NAN];
    assign out_snan   = out_q.cls[CLS_SNAN];

endmodule
